// File: rtl/alarm_check_minigame.sv
// Alarm compare and silence logic: rings on a rising time match and silences only
// after the user copies ROUNDS random LED patterns onto the switches before timeout.
module alarm_check_minigame #(
   parameter int ROUNDS    = 3,
   parameter int GAME_SECS = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spdt4,
   input  logic        sec_tick,
   input  logic [15:0] current_time,
   input  logic [15:0] alarm_time,
   input  logic        push_m,
   input  logic [9:0]  mini_game,
   output logic [9:0]  mini_game_led,
   output logic        ring_led,
   output logic [15:0] num,
   output logic [2:0]  alarm_state,
   output logic        finish4
);

   typedef enum logic [1:0] {IDLE, RING, GAME, DONE} state_t;

   localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);
   localparam logic [7:0] TMO_INIT = {4'(GAME_SECS / 10), 4'(GAME_SECS % 10)};

   state_t      state_q, state_d;
   logic        match_q, push_q, hit_q, hit_d;
   logic [9:0]  lfsr_q, lfsr_d;
   logic [3:0]  round_q, round_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [9:0]  led_q, led_d;
   logic        ring_q, ring_d;
   logic        fin_q, fin_d;
   logic [15:0] num_q, num_d;
   logic [2:0]  ast_q, ast_d;
   logic        match, trigger, press, eq, complete;

   assign match    = (current_time == alarm_time);
   assign trigger  = match & ~match_q;
   assign press    = push_m & ~push_q;
   assign eq       = (mini_game == led_q);
   assign complete = (state_q == GAME) && eq && hit_q;
   // Fibonacci taps at bits 10 and 7 (x^10 + x^7 + 1)
   assign lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      tmo_d   = tmo_q;
      led_d   = led_q;
      ring_d  = ring_q;
      fin_d   = 1'b0;
      hit_d   = 1'b0;
      case (state_q)
         IDLE: begin
            ring_d = 1'b0;
            if (trigger) state_d = RING;
         end
         RING: begin
            if (sec_tick) ring_d = ~ring_q;
            if (press) begin
               state_d = GAME;
               round_d = 4'd1;
               tmo_d   = TMO_INIT;
               led_d   = lfsr_q;
               ring_d  = 1'b0;
            end
         end
         GAME: begin
            ring_d = 1'b0;
            hit_d  = eq & ~complete;
            if (complete) begin
               if (round_q >= ROUNDS_L) begin
                  state_d = DONE;
                  led_d   = '0;
                  fin_d   = 1'b1;
               end else begin
                  round_d = round_q + 4'd1;
                  led_d   = lfsr_q;
                  tmo_d   = TMO_INIT;
               end
            end else if (sec_tick) begin
               if (tmo_q == 8'h00) begin
                  state_d = RING;
                  round_d = 4'd0;
                  led_d   = '0;
               end else if (tmo_q[3:0] == 4'd0) begin
                  tmo_d = {tmo_q[7:4] - 4'd1, 4'd9};
               end else begin
                  tmo_d = {tmo_q[7:4], tmo_q[3:0] - 4'd1};
               end
            end
         end
         DONE: begin
            led_d = '0;
            if (sec_tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (!spdt4) begin
         state_d = IDLE;
         led_d   = '0;
         ring_d  = 1'b0;
         fin_d   = 1'b0;
         hit_d   = 1'b0;
      end
   end

   // Display and status registers follow the state being entered
   always_comb begin
      num_d = current_time;
      ast_d = 3'b000;
      case (state_d)
         RING: begin
            num_d = alarm_time;
            ast_d = 3'b001;
         end
         GAME: begin
            num_d = {4'd0, round_d, tmo_d};
            ast_d = 3'b010;
         end
         DONE: ast_d = 3'b100;
         default: ast_d = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         match_q <= 1'b0;
         push_q  <= 1'b0;
         hit_q   <= 1'b0;
         lfsr_q  <= 10'h001;
         round_q <= 4'd0;
         tmo_q   <= TMO_INIT;
         led_q   <= '0;
         ring_q  <= 1'b0;
         fin_q   <= 1'b0;
         num_q   <= '0;
         ast_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         match_q <= match;
         push_q  <= push_m;
         hit_q   <= hit_d;
         lfsr_q  <= lfsr_d;
         round_q <= round_d;
         tmo_q   <= tmo_d;
         led_q   <= led_d;
         ring_q  <= ring_d;
         fin_q   <= fin_d;
         num_q   <= num_d;
         ast_q   <= ast_d;
      end
   end

   assign mini_game_led = led_q;
   assign ring_led      = ring_q;
   assign num           = num_q;
   assign alarm_state   = ast_q;
   assign finish4       = fin_q;

endmodule

// File: doc/alarm_check_minigame.md
# alarm_check_minigame

Service 4 of the alarm clock. Compares the running `current_time` against the stored `alarm_time`, rings when they match, and silences the alarm only after the user clears a three-round switch-matching mini game. It consumes the time and alarm values produced by the top level and Service 2, and feeds `num`, `mini_game_led`, `alarm_state` and `finish4` back to the display, LED and service-LED logic in the top level.

## Interface
Parameters:
- `ROUNDS`, 3: number of patterns the user must match to silence the alarm (1..9).
- `GAME_SECS`, 30: game timeout in seconds, two BCD digits (1..99).

Ports:
- `clk` in 1: system clock; the slow clock that also advances `current_time`.
- `reset` in 1: reset; synchronous, active-high.
- `spdt4` in 1: service enable (Service 4 switch).
- `sec_tick` in 1: one-cycle strobe, once per second.
- `current_time` in 16: BCD MM:SS, i.e. {M1,M0,S1,S0}.
- `alarm_time` in 16: BCD MM:SS.
- `push_m` in 1: middle push button, level.
- `mini_game` in 10: mini-game switch levels.
- `mini_game_led` out 10: target pattern for the current round.
- `ring_led` out 1: blinking alarm indicator.
- `num` out 16: four BCD digits sent to the 7-segment mux.
- `alarm_state` out 3: 000 idle, 001 alarm on, 010 mini game, 100 alarm off.
- `finish4` out 1: one-cycle pulse when the alarm is silenced.

## Operation
- Every output comes from a register. On `reset`: state IDLE, `alarm_state`=000, `mini_game_led`=0, `ring_led`=0, `finish4`=0, `num`=0000, round=0, timeout=`GAME_SECS`, LFSR=10'h001, `match_q`=0, `push_q`=0.
- Trigger logic:
  - `match = (current_time == alarm_time)`; `match_q` registers it.
  - A trigger is `match & ~match_q`, a rising edge. A time that stays equal to the alarm fires only once.
- Button: `push_q` registers `push_m`; a press is `push_m & ~push_q`.
- LFSR: 10-bit Fibonacci, polynomial x^10+x^7+1, steps every cycle. It never reaches 0.
- IDLE:
  - `num` = `current_time`.
  - A trigger while `spdt4`=1 moves to RING.
- RING:
  - `alarm_state`=001 and `num` = `alarm_time`.
  - `ring_led` toggles on each `sec_tick`.
  - A press moves to GAME, loads round=1 and timeout=`GAME_SECS`, and latches the LFSR value into `mini_game_led`.
- GAME:
  - `alarm_state`=010, `ring_led`=0.
  - `num` = {4'd0, round, timeout tens, timeout units}.
  - Match rule: `mini_game == mini_game_led` for 2 consecutive cycles completes the round.
  - If round < `ROUNDS`: round+1, latch a new LFSR value, reload timeout.
  - If round = `ROUNDS`: go to DONE.
  - Timeout is a BCD down-counter decremented on `sec_tick` (units 0 borrows: tens-1, units 9).
  - A `sec_tick` while timeout = 00 returns to RING with round=0 and `mini_game_led`=0.
  - Completion and expiry in the same cycle: completion wins.
  - `push_m` is ignored in GAME.
- DONE:
  - `alarm_state`=100, `mini_game_led`=0, `num` = `current_time`.
  - `finish4`=1 in the first DONE cycle only.
  - The next `sec_tick` returns to IDLE. Triggers in DONE are ignored.
- `spdt4`=0 in any state: next cycle IDLE with outputs at reset values, except `num` = `current_time`. No `finish4` is issued. Timers and the LFSR are not reset.
- `reset` takes priority over everything, in any state.

## Timing
- Trigger latency: if `current_time` first equals `alarm_time` in cycle N, then `alarm_state`=001 from cycle N+1.
- RING -> GAME: a press at cycle N gives state 010 and the new pattern at N+1.
- Round completion: a match held in cycles N and N+1 gives the new round or DONE at N+2.
- Timeout: `GAME_SECS` whole ticks after entry, plus the tick at 00. Expiry takes effect the cycle after that tick.
- `finish4` is exactly 1 cycle wide.
- `spdt4` fall gives IDLE 1 cycle later.

## Test plan
- Alarm 0001, time counts 0000 -> 0001 with `spdt4`=1 -> `alarm_state` goes 001 one cycle later; `num`=0001; `ring_led` toggles on each tick; time held at 0001 for 5 cycles gives no retrigger after DONE.
- In RING, press `push_m`, then copy `mini_game_led` onto `mini_game` for 2 cycles, three times -> round shows 1, 2, 3 in `num`[11:8]; patterns are nonzero and differ round to round; then `alarm_state`=100, a single `finish4` pulse, and IDLE after the next tick.
- In GAME, no match, 31 ticks -> `num` counts 0130 ... 0100; after the 00 tick, `alarm_state`=001 and `mini_game_led`=0.
- Switches match for only 1 cycle, then change -> round does not advance.
- `spdt4` dropped mid-GAME -> IDLE next cycle, `finish4` never pulses, `mini_game_led`=0.
- Synchronous `reset` asserted in RING -> all outputs take their reset values at the next clock edge; a match after release triggers only on a fresh rising edge.
